jtbubl_prog_loader: RTL and testbench
=====================================

// Module: jtbubl_prog_loader
// PURPOSE
//  Upstream ROM-download stage for the Bubble Bobble/Tokio core. It converts the byte-wide
//  ioctl stream into SDRAM programming writes (prog_*), plus one-cycle PROM write strobes.
//  It paces SDRAM writes against sdram_ack through a 2-entry queue and flags the Tokio set.
//  Its outputs drive the game top's prog_* ports, its PROM loader and its tokio select.
// PARAMETERS
//  PROM_START  25'hC_0000  first ioctl byte address routed to PROMs instead of SDRAM
//  AW          22          SDRAM word-address width of prog_addr
// PORTS
//  clk          in   1   system clock; single clock domain
//  rstn         in   1   asynchronous, active-low reset
//  downloading  in   1   high while the ROM download is in progress
//  ioctl_addr   in   25  byte address of the incoming byte
//  ioctl_dout   in   8   incoming byte
//  ioctl_wr     in   1   one-cycle strobe: ioctl_addr/ioctl_dout are valid
//  sdram_ack    in   1   SDRAM has accepted the current prog_we write
//  prog_addr    out  AW  SDRAM word address (byte address>>1) or PROM byte offset
//  prog_data    out  8   byte to write
//  prog_mask    out  2   active-low byte enable: 2'b10 = low byte, 2'b01 = high byte
//  prog_we      out  1   SDRAM write request, level, held until acknowledged
//  prom_we      out  1   one-cycle PROM write strobe
//  tokio        out  1   set when the byte at address 0 equals 8'h7e
//  dwnld_busy   out  1   download active or SDRAM writes still pending
//  ovf          out  1   sticky: an SDRAM byte was dropped because the queue was full
// BEHAVIOUR
//  - Reset (rstn=0, async): all outputs 0, queue emptied, FSM=IDLE. Reset mid-write aborts
//    the write, and prog_we drops immediately.
//  - Routing on ioctl_wr, address A:
//    * A>=PROM_START: next edge sets prom_we=1 for exactly one cycle.
//      prog_addr=A-PROM_START (truncated to AW), prog_data=dout. The queue is bypassed and
//      the SDRAM FSM is untouched. If an SDRAM write is in REQ, prog_addr/prog_data are NOT
//      overwritten: the PROM byte is held in a side register and strobed once FSM leaves REQ.
//    * A<PROM_START: {A[AW:1], A[0], dout} is pushed into the 2-entry FIFO.
//  - tokio: on ioctl_wr with A==0, tokio<=(dout==8'h7e); otherwise it holds its value.
//  - SDRAM FSM states:
//    * IDLE: FIFO non-empty -> pop the head; drive prog_addr=A>>1, prog_data, and
//      prog_mask=A[0]?2'b01:2'b10; prog_we<=1; go to REQ.
//      Latency is ioctl_wr at edge n -> push at n -> prog_we high after edge n+1.
//    * REQ: hold prog_we/addr/data/mask stable. On sdram_ack=1: prog_we<=0, go to GAP.
//    * GAP: exactly one cycle with prog_we=0 (edge-detect guard), then go to IDLE.
//  - FIFO: depth 2.
//    * Push while full: the byte is dropped and ovf<=1.
//    * Pop and push in the same cycle while full: both are performed; no overflow.
//    * ovf clears on the rising edge of downloading.
//  - dwnld_busy = downloading | FIFO non-empty | FSM!=IDLE | pending PROM byte. It falls
//    only after the last ack plus the GAP cycle.
//  - Ignored inputs: ioctl_wr while downloading=0; sdram_ack outside REQ.
//  - Write ordering: SDRAM writes are issued in ioctl order. PROM strobes keep ioctl order
//    among themselves.
// TESTING
//  1. Write A=0,dout=7e; ack 3 cycles later -> prog_addr=0, mask=2'b10, prog_we high 3
//     cycles, then a 1-cycle gap; tokio=1.
//  2. Write A=1,dout=55 -> prog_addr=0, prog_data=55, mask=2'b01. Then write A=0,dout=00
//     -> tokio=0.
//  3. Three back-to-back bytes A=2,3,4 with ack held off 10 cycles -> first in REQ, two
//     queued, ovf=0. A fourth byte -> ovf=1; after acks, writes to words 1,1,2 in order.
//  4. A=C_0005,dout=0A while FSM IDLE -> prom_we 1 cycle, prog_addr=5, prog_data=0A.
//     Same byte during REQ -> strobe after the ack, prog_addr unchanged during REQ.
//  5. downloading falls with 2 bytes queued -> dwnld_busy stays 1 until the 2nd ack+GAP,
//     then 0. The next downloading rise clears ovf.
//  6. rstn low during REQ -> prog_we, prom_we, tokio, ovf and dwnld_busy all 0 the same
//     cycle. After release, a new write starts cleanly from IDLE.

Source files
------------

// File: rtl/jtbubl_prog_loader.sv
// Turns the byte-wide ioctl ROM download into paced SDRAM programming writes
// (through a 2-entry queue) and one-cycle PROM write strobes. Flags the Tokio set.
module jtbubl_prog_loader #(
  parameter logic [24:0] PROM_START = 25'hC_0000,
  parameter int          AW         = 22
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          downloading,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  input  logic          ioctl_wr,
  input  logic          sdram_ack,
  output logic [AW-1:0] prog_addr,
  output logic [7:0]    prog_data,
  output logic [1:0]    prog_mask,
  output logic          prog_we,
  output logic          prom_we,
  output logic          tokio,
  output logic          dwnld_busy,
  output logic          ovf,
  output logic [1:0]    fsm_state
);

  // Handshake: prog_we is a level request that holds address/data/mask stable;
  // the write completes on the clock edge where prog_we and sdram_ack are both high.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GAP = 2'd2} state_t;

  localparam int EW = AW + 9;  // {word address, byte select, data}

  state_t        state;
  logic [EW-1:0] fifo_mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          dl_d;
  logic          prom_pend;
  logic [AW-1:0] pend_addr;
  logic [7:0]    pend_data;

  logic          wr_en;
  logic          is_prom;
  logic          sd_req;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          prom_new;
  logic          prom_block;
  logic [AW-1:0] prom_off;
  logic [EW-1:0] new_entry;
  logic [EW-1:0] head;

  always_comb begin
    wr_en      = ioctl_wr & downloading;
    is_prom    = ioctl_addr >= PROM_START;
    sd_req     = wr_en & ~is_prom;
    prom_new   = wr_en & is_prom;
    full       = count == 2'd2;
    pop        = (state == IDLE) && (count != 2'd0);
    // A full queue still accepts a byte on the same edge its head is popped.
    push       = sd_req & (~full | pop);
    drop       = sd_req & full & ~pop;
    // PROM strobes must not disturb prog_addr/prog_data while an SDRAM write owns them.
    prom_block = (state == REQ) | pop;
    prom_off   = AW'(ioctl_addr - PROM_START);
    new_entry  = {ioctl_addr[AW:1], ioctl_addr[0], ioctl_dout};
    head       = fifo_mem[rd_ptr];
  end

  assign dwnld_busy = dl_d | (count != 2'd0) | (state != IDLE) | prom_pend;
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      dl_d        <= 1'b0;
      prom_pend   <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= 8'd0;
      prog_addr   <= '0;
      prog_data   <= 8'd0;
      prog_mask   <= 2'd0;
      prog_we     <= 1'b0;
      prom_we     <= 1'b0;
      tokio       <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      prom_we <= 1'b0;
      dl_d    <= downloading;

      if (push) begin
        fifo_mem[wr_ptr] <= new_entry;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase

      if (downloading && !dl_d) ovf <= 1'b0;
      if (drop) ovf <= 1'b1;

      if (wr_en && ioctl_addr == 25'd0) tokio <= (ioctl_dout == 8'h7e);

      case (state)
        IDLE: if (pop) begin
          prog_addr <= head[EW-1:9];
          prog_data <= head[7:0];
          prog_mask <= head[8] ? 2'b01 : 2'b10;
          prog_we   <= 1'b1;
          state     <= REQ;
        end
        REQ: if (sdram_ack) begin
          prog_we <= 1'b0;
          state   <= GAP;
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // A held PROM byte always goes out before a newer one to keep PROM order.
      if (!prom_block) begin
        if (prom_pend) begin
          prom_we   <= 1'b1;
          prog_addr <= pend_addr;
          prog_data <= pend_data;
          prom_pend <= prom_new;
          if (prom_new) begin
            pend_addr <= prom_off;
            pend_data <= ioctl_dout;
          end
        end else if (prom_new) begin
          prom_we   <= 1'b1;
          prog_addr <= prom_off;
          prog_data <= ioctl_dout;
        end
      end else if (prom_new && !prom_pend) begin
        prom_pend <= 1'b1;
        pend_addr <= prom_off;
        pend_data <= ioctl_dout;
      end
    end
  end

endmodule

// File: tb/tb_jtbubl_prog_loader.sv
// Bench for jtbubl_prog_loader: a timing model of SDRAM writes/PROM strobes derived
// from push edges and ack delay, checked every cycle, plus hand-computed literals.
module tb_jtbubl_prog_loader;

  localparam logic [24:0] PROM_START = 25'hC_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic        sdram_ack;
  logic [21:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic        prom_we;
  logic        tokio;
  logic        dwnld_busy;
  logic        ovf;
  logic [1:0]  fsm_state;

  jtbubl_prog_loader #(.PROM_START(PROM_START), .AW(22)) dut (
    .clk(clk), .rstn(rstn), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .sdram_ack(sdram_ack), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_mask(prog_mask), .prog_we(prog_we), .prom_we(prom_we), .tokio(tokio),
    .dwnld_busy(dwnld_busy), .ovf(ovf), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  typedef struct {
    int          push;
    int          rise;
    int          fall;
    logic [21:0] addr;
    logic [7:0]  data;
    logic [1:0]  mask;
  } wr_t;
  typedef struct {
    logic [21:0] addr;
    logic [7:0]  data;
  } pr_t;

  wr_t         wq[$];
  pr_t         pq[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          last_fall = -100;
  int          ack_delay = 3;
  logic        tokio_m = 1'b0;
  logic        ovf_m = 1'b0;
  logic        dl_prev = 1'b0;
  logic        prev_we = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_clear();
    wq.delete(); pq.delete(); exp_q.delete();
    last_fall = -100; tokio_m = 1'b0; ovf_m = 1'b0;
  endtask

  // Called at the edge that samples the write; p is that edge's index.
  task automatic model_write(input logic [24:0] a, input logic [7:0] d);
    int p, occ;
    wr_t w;
    pr_t e;
    logic [24:0] off;
    if (!downloading) return;
    p = cyc + 1;
    if (a == 25'd0) tokio_m = (d == 8'h7e);
    if (a >= PROM_START) begin
      off = a - PROM_START;
      e.addr = off[21:0];
      e.data = d;
      pq.push_back(e);
    end else begin
      occ = 0;
      foreach (wq[i]) if (wq[i].push < p && wq[i].rise > p) occ++;
      if (occ >= 2) ovf_m = 1'b1;
      else begin
        w.push = p;
        w.rise = (p + 1 > last_fall + 2) ? p + 1 : last_fall + 2;
        w.fall = w.rise + ack_delay;
        w.addr = a[22:1];
        w.data = d;
        w.mask = a[0] ? 2'b01 : 2'b10;
        last_fall = w.fall;
        wq.push_back(w);
        exp_q.push_back({w.addr, w.data, w.mask});
      end
    end
  endtask

  // ---------------- ack responder ----------------
  logic ack_r = 1'b0;
  logic stray = 1'b0;
  int   ack_cnt = 0;
  assign sdram_ack = ack_r | stray;

  always @(negedge clk) begin
    if (!rstn || !prog_we) begin
      ack_cnt = 0;
      ack_r   = 1'b0;
    end else begin
      ack_cnt++;
      ack_r = (ack_cnt == ack_delay);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    logic exp_we, blocked, busy_w, exp_prom;
    wr_t  cur;
    #1;
    cyc++;
    if (!rstn) begin
      dl_prev = 1'b0;
      prev_we = 1'b0;
    end else begin
      if (downloading && !dl_prev) ovf_m = 1'b0;
      dl_prev = downloading;
      exp_we = 1'b0; blocked = 1'b0; busy_w = 1'b0;
      cur = '{default: 0};
      foreach (wq[i]) begin
        if (wq[i].rise <= cyc && cyc < wq[i].fall) begin exp_we = 1'b1; cur = wq[i]; end
        if (wq[i].rise <= cyc && cyc <= wq[i].fall) blocked = 1'b1;
        if (wq[i].push <= cyc && cyc <= wq[i].fall) busy_w = 1'b1;
      end
      chk("prog_we", {31'd0, prog_we}, {31'd0, exp_we});
      if (prog_we && !prev_we) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_order: got unexpected write %h, expected none", {prog_addr, prog_data, prog_mask});
        end else chk("write_order", {prog_addr, prog_data, prog_mask}, exp_q.pop_front());
      end
      if (exp_we) chk("req_fields", {prog_addr, prog_data, prog_mask}, {cur.addr, cur.data, cur.mask});
      exp_prom = (pq.size() != 0) && !blocked;
      chk("prom_we", {31'd0, prom_we}, {31'd0, exp_prom});
      if (prom_we && exp_prom) begin
        chk("prom_fields", {2'd0, prog_addr, prog_data}, {2'd0, pq[0].addr, pq[0].data});
        void'(pq.pop_front());
      end
      chk("ovf", {31'd0, ovf}, {31'd0, ovf_m});
      chk("tokio", {31'd0, tokio}, {31'd0, tokio_m});
      chk("dwnld_busy", {31'd0, dwnld_busy}, {31'd0, downloading | busy_w | (pq.size() != 0)});
      prev_we = prog_we;
    end
  end

  // ---------------- driver tasks (called and returning at a negedge) ----------------
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(posedge clk);
    model_write(a, d);
    @(negedge clk);
    ioctl_wr = 1'b0;
  endtask

  task automatic wr_at(input int e, input logic [24:0] a, input logic [7:0] d);
    while (cyc < e - 1) @(negedge clk);
    wr_byte(a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((cyc <= last_fall + 1 || pq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      errors++;
      $display("FAIL quiet_timeout: got still busy after %0d cycles, expected drained", n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int e, n;
    rstn = 1'b0; downloading = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; ioctl_wr = 1'b0;
    idle(3);
    chk("rst_prog_we", {31'd0, prog_we}, 0);
    chk("rst_prom_we", {31'd0, prom_we}, 0);
    chk("rst_tokio", {31'd0, tokio}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_busy", {31'd0, dwnld_busy}, 0);
    chk("rst_fsm_idle", {30'd0, fsm_state}, 0);
    rstn = 1'b1;
    downloading = 1'b1;
    idle(2);

    // 1: byte 0 = 7e, ack after 3 cycles
    ack_delay = 3;
    wr_byte(25'd0, 8'h7e);
    e = cyc;
    chk("t1_we_latency", {31'd0, prog_we}, 0);
    chk("t1_tokio", {31'd0, tokio}, 1);
    idle(1);
    chk("t1_fields", {prog_we, prog_addr, prog_data, prog_mask}, {1'b1, 22'd0, 8'h7e, 2'b10});
    idle(2);
    chk("t1_we_3rd", {31'd0, prog_we}, 1);
    idle(1);
    chk("t1_we_drop", {31'd0, prog_we}, 0);
    chk("t1_edge", cyc, e + 4);
    wait_quiet();

    // 2: high byte of word 0, then tokio cleared
    wr_byte(25'd1, 8'h55);
    idle(1);
    chk("t2_fields", {prog_addr, prog_data, prog_mask}, {22'd0, 8'h55, 2'b01});
    wait_quiet();
    wr_byte(25'd0, 8'h00);
    chk("t2_tokio", {31'd0, tokio}, 0);
    wait_quiet();

    // 3: queue fills under slow ack, fourth byte is dropped
    ack_delay = 10;
    wr_byte(25'd2, 8'ha1);
    wr_byte(25'd3, 8'ha2);
    wr_byte(25'd4, 8'ha3);
    chk("t3_ovf_clear", {31'd0, ovf}, 0);
    chk("t3_req", {31'd0, prog_we}, 1);
    wr_byte(25'd6, 8'ha4);
    chk("t3_ovf_set", {31'd0, ovf}, 1);
    wait_quiet();

    // 4: PROM byte while idle, then while an SDRAM write is in REQ
    ack_delay = 3;
    wr_byte(PROM_START + 25'd5, 8'h0a);
    chk("t4_prom", {prom_we, prog_addr, prog_data}, {1'b1, 22'd5, 8'h0a});
    idle(1);
    chk("t4_prom_1cyc", {31'd0, prom_we}, 0);
    idle(2);
    wr_byte(25'd8, 8'h11);
    e = cyc;
    idle(1);
    wr_byte(PROM_START + 25'd5, 8'h0b);
    chk("t4_hold", {prom_we, prog_addr}, {1'b0, 22'd4});
    idle(2);
    chk("t4_at_ack", {prog_we, prom_we}, 0);
    idle(1);
    chk("t4_late_prom", {prom_we, prog_addr, prog_data}, {1'b1, 22'd5, 8'h0b});
    chk("t4_late_edge", cyc, e + 5);
    wait_quiet();

    // stray ack outside REQ is ignored
    stray = 1'b1;
    idle(1);
    stray = 1'b0;
    idle(3);

    // 5: download ends with two bytes queued; busy holds to last ack + gap
    ack_delay = 6;
    wr_byte(25'h10, 8'h21);
    e = cyc;
    wr_byte(25'h11, 8'h22);
    wr_byte(25'h12, 8'h23);
    downloading = 1'b0;
    wr_byte(25'd0, 8'h7e);
    chk("t5_ignored", {31'd0, tokio}, 0);
    n = 0;
    while (dwnld_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_busy_fall_edge", cyc, e + 24);
    chk("t5_ovf_kept", {31'd0, ovf}, 1);
    downloading = 1'b1;
    idle(1);
    chk("t5_ovf_cleared", {31'd0, ovf}, 0);
    idle(2);

    // 5b: push into a full queue on the pop edge is accepted
    wr_byte(25'h20, 8'h31);
    e = cyc;
    wr_byte(25'h21, 8'h32);
    wr_byte(25'h22, 8'h33);
    wr_at(e + 9, 25'h23, 8'h34);
    chk("t5b_no_ovf", {31'd0, ovf}, 0);
    wait_quiet();

    // 6: reset in the middle of a write
    ack_delay = 10;
    wr_byte(25'd0, 8'h7e);
    wr_byte(25'h30, 8'h41);
    wr_byte(25'h31, 8'h42);
    wr_byte(25'h32, 8'h43);
    chk("t6_pre", {prog_we, tokio, ovf}, 3'b111);
    rstn = 1'b0;
    #1;
    chk("t6_rst_outputs", {prog_we, prom_we, tokio, ovf, dwnld_busy}, 5'b0);
    model_clear();
    idle(2);
    rstn = 1'b1;
    ack_delay = 3;
    idle(2);
    wr_byte(25'h40, 8'h5a);
    idle(1);
    chk("t6_restart", {prog_we, prog_addr, prog_data, prog_mask}, {1'b1, 22'h20, 8'h5a, 2'b10});
    wait_quiet();

    chk("exp_q_empty", exp_q.size(), 0);
    chk("prom_q_empty", pq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
